// File: rtl/ccd_frame_packer_if.sv
// Pixel-stream input and DMEM port-b write bus of the CCD frame packer.
// The master side is the camera/testbench; the slave side is the packer.
interface ccd_frame_packer_if #(
  parameter int PIX_W  = 8,
  parameter int WORD_W = 256,
  parameter int ADDR_W = 11
) ();
  logic              pix_valid;
  logic              pix_sof;
  logic [PIX_W-1:0]  pix_data;
  logic              dmem_wren;
  logic [ADDR_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wrdata;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  dmem_wren, dmem_addr, dmem_wrdata
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output dmem_wren, dmem_addr, dmem_wrdata
  );
endinterface

// File: rtl/ccd_frame_packer.sv
// Packs a grayscale pixel stream into wide DMEM words written at sequential
// addresses, and raises img_done once the whole frame is in memory.
//
// state   | meaning
// IDLE    | disarmed, pixels ignored
// ARMED   | waiting for a start-of-frame pixel
// CAPTURE | packing pixels, one DMEM write per completed word
// DONE    | frame written, img_done held until enable drops
module ccd_frame_packer #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 32,
  parameter int FRAME_PIX    = 784,
  parameter int ADDR_W       = 11,
  parameter int BASE_ADDR    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  ccd_frame_packer_if.slave io_bus,
  output logic              o_img_done,
  output logic              o_busy
);
  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int CNT_W  = $clog2(FRAME_PIX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LANE_W-1:0] r_lane;
  logic [ADDR_W-1:0] r_word_idx;
  logic [WORD_W-1:0] r_pack;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wrdata;
  logic              r_done;

  logic              w_restart;
  logic              w_accept;
  logic [LANE_W-1:0] w_lane;
  logic [CNT_W-1:0]  w_cnt;
  logic [ADDR_W-1:0] w_widx;
  logic [WORD_W-1:0] w_pack_base;
  logic [WORD_W-1:0] w_pack_new;
  logic              w_last;
  logic              w_word_full;

  // A qualified sof in ARMED or CAPTURE starts the frame over at pixel 0.
  assign w_restart = i_enable & io_bus.pix_valid & io_bus.pix_sof &
                     ((r_state == S_ARMED) | (r_state == S_CAPTURE));
  assign w_accept  = i_enable & io_bus.pix_valid &
                     ((r_state == S_CAPTURE) | w_restart);

  assign w_lane      = w_restart ? '0 : r_lane;
  assign w_cnt       = w_restart ? '0 : r_cnt;
  assign w_widx      = w_restart ? '0 : r_word_idx;
  assign w_pack_base = w_restart ? '0 : r_pack;

  assign w_last      = (w_cnt == CNT_W'(FRAME_PIX - 1));
  assign w_word_full = (w_lane == LANE_W'(PIX_PER_WORD - 1)) | w_last;

  always_comb begin
    w_pack_new = w_pack_base;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (w_lane == LANE_W'(k)) w_pack_new[PIX_W*k +: PIX_W] = io_bus.pix_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_lane     <= '0;
      r_word_idx <= '0;
      r_pack     <= '0;
      r_wren     <= 1'b0;
      r_addr     <= '0;
      r_wrdata   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_wren <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_enable) r_state <= S_ARMED;
        end
        S_ARMED, S_CAPTURE: begin
          if (!i_enable)    r_state <= S_IDLE;
          else if (w_accept) r_state <= w_last ? S_DONE : S_CAPTURE;
        end
        S_DONE: begin
          if (!i_enable) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else begin
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // The write strobe is registered, so it lands the cycle after the
      // pixel that completes a word; partial final words keep zero lanes.
      if (w_accept) begin
        r_cnt <= w_cnt + CNT_W'(1);
        if (w_word_full) begin
          r_wren     <= 1'b1;
          r_addr     <= ADDR_W'(BASE_ADDR) + w_widx;
          r_wrdata   <= w_pack_new;
          r_pack     <= '0;
          r_lane     <= '0;
          r_word_idx <= w_widx + ADDR_W'(1);
        end else begin
          r_pack     <= w_pack_new;
          r_lane     <= w_lane + LANE_W'(1);
          r_word_idx <= w_widx;
        end
      end
    end
  end

  assign io_bus.dmem_wren   = r_wren;
  assign io_bus.dmem_addr   = r_addr;
  assign io_bus.dmem_wrdata = r_wrdata;
  assign o_img_done         = r_done;
  assign o_busy             = (r_state == S_ARMED) | (r_state == S_CAPTURE);
endmodule

// File: tb/tb_ccd_frame_packer.sv
// Bench for ccd_frame_packer: two instances (base 0 and base 100) share one
// stimulus stream and are compared against a queue-based frame model.
module tb_ccd_frame_packer;
  localparam int F   = 784;
  localparam int PPW = 32;
  localparam int B1  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       v_valid = 1'b0;
  logic       v_sof   = 1'b0;
  logic [7:0] v_data  = 8'h00;
  logic       done0, done1, busy0, busy1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ccd_frame_packer_if #(.PIX_W(8), .WORD_W(256), .ADDR_W(11)) bus0 ();
  ccd_frame_packer_if #(.PIX_W(8), .WORD_W(256), .ADDR_W(11)) bus1 ();

  assign bus0.pix_valid = v_valid;
  assign bus0.pix_sof   = v_sof;
  assign bus0.pix_data  = v_data;
  assign bus1.pix_valid = v_valid;
  assign bus1.pix_sof   = v_sof;
  assign bus1.pix_data  = v_data;

  ccd_frame_packer #(.BASE_ADDR(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .io_bus(bus0),
    .o_img_done(done0), .o_busy(busy0)
  );
  ccd_frame_packer #(.BASE_ADDR(B1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .io_bus(bus1),
    .o_img_done(done1), .o_busy(busy1)
  );

  typedef struct {
    int           cyc;
    logic         w0, w1;
    logic [10:0]  a0, a1;
    logic [255:0] d0, d1;
  } mon_t;
  typedef struct {
    int           idx;
    logic [255:0] data;
    int           cyc;
  } exp_t;

  mon_t mon_q[$];
  exp_t exp_q[$];
  int   d0_q[$];
  int   d1_q[$];
  int   dexp_q[$];
  logic pd0 = 1'b0, pd1 = 1'b0;

  always @(negedge clk) begin
    if (bus0.dmem_wren || bus1.dmem_wren)
      mon_q.push_back('{cyc, bus0.dmem_wren, bus1.dmem_wren, bus0.dmem_addr,
                        bus1.dmem_addr, bus0.dmem_wrdata, bus1.dmem_wrdata});
    if (done0 && !pd0) d0_q.push_back(cyc);
    if (done1 && !pd1) d1_q.push_back(cyc);
    pd0 <= done0;
    pd1 <= done1;
  end

  // Reference model: the frame is a list of accepted pixels; every full
  // group of PPW (or the frame tail) becomes one expected word.
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;
  int         m_mode = M_IDLE;
  logic [7:0] m_pix[$];
  int         m_word = 0;

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    v_valid = v;
    v_sof   = s;
    v_data  = d;
    if (en && v && ((m_mode == M_ARMED && s) || m_mode == M_CAP)) begin
      if (s) begin
        m_pix.delete();
        m_word = 0;
      end
      m_pix.push_back(d);
      m_mode = M_CAP;
      if (m_pix.size() % PPW == 0 || m_pix.size() == F) begin : emit
        exp_t e;
        e.idx  = m_word;
        e.cyc  = cyc + 1;
        e.data = '0;
        for (int i = PPW*m_word; i < m_pix.size(); i++)
          e.data[8*(i - PPW*m_word) +: 8] = m_pix[i];
        exp_q.push_back(e);
        m_word++;
      end
      if (m_pix.size() == F) begin
        m_mode = M_DONE;
        dexp_q.push_back(cyc + 2);
      end
    end
    if (!en) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) m_mode = M_ARMED;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic clear_logs();
    mon_q.delete();
    exp_q.delete();
    d0_q.delete();
    d1_q.delete();
    dexp_q.delete();
  endtask

  task automatic rearm();
    en = 1'b0;
    idle(2);
    clear_logs();
    en = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({bus0.dmem_wren, bus1.dmem_wren, done0, done1, busy0, busy1} !== 6'b0 ||
        bus0.dmem_addr !== 11'd0 || bus1.dmem_addr !== 11'd0 ||
        bus0.dmem_wrdata !== 256'd0 || bus1.dmem_wrdata !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_init: wren %b/%b done %b/%b busy %b/%b addr %0d/%0d, expected all 0",
               bus0.dmem_wren, bus1.dmem_wren, done0, done1, busy0, busy1, bus0.dmem_addr, bus1.dmem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = M_IDLE;
    clear_logs();
    en = 1'b1;
    idle(1);
    for (int i = 0; i < 40; i++) drive(1'b1, i == 0, 8'($urandom));
    n_tests++;
    if (mon_q.size() != exp_q.size() || mon_q.size() != 1) begin
      n_fail++;
      $display("FAIL reset_prewrite: %0d writes, expected 1", mon_q.size());
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus0.dmem_wren, bus1.dmem_wren, done0, done1, busy0, busy1} !== 6'b0 ||
        bus0.dmem_addr !== 11'd0 || bus1.dmem_addr !== 11'd0 ||
        bus0.dmem_wrdata !== 256'd0 || bus1.dmem_wrdata !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_async: wren %b/%b busy %b/%b addr %0d/%0d, expected all 0",
               bus0.dmem_wren, bus1.dmem_wren, busy0, busy1, bus0.dmem_addr, bus1.dmem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = M_IDLE;
    m_pix.delete();
    clear_logs();
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 8'($urandom));
    n_tests++;
    if (mon_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_nosof: %0d writes, expected 0", mon_q.size());
    end
    n_tests++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_armed_busy: busy %b/%b, expected 1", busy0, busy1);
    end
  endtask

  task automatic test_full_frame();
    logic [255:0] w0c;
    int lastc;
    rearm();
    for (int i = 0; i < F; i++) begin
      if (i == F-1) lastc = cyc;
      drive(1'b1, i == 0, 8'(i));
    end
    idle(4);
    n_tests++;
    if (mon_q.size() != exp_q.size() || mon_q.size() != 25) begin
      n_fail++;
      $display("FAIL full_count: %0d writes, expected 25", mon_q.size());
    end
    foreach (exp_q[i]) if (i < mon_q.size()) begin
      n_tests++;
      if (mon_q[i].cyc != exp_q[i].cyc || mon_q[i].w0 !== 1'b1 || mon_q[i].w1 !== 1'b1 ||
          mon_q[i].a0 !== 11'(exp_q[i].idx) || mon_q[i].a1 !== 11'(exp_q[i].idx + B1) ||
          mon_q[i].d0 !== exp_q[i].data || mon_q[i].d1 !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL full_word%0d: cyc %0d addr %0d/%0d data %h, expected cyc %0d addr %0d data %h",
                 i, mon_q[i].cyc, mon_q[i].a0, mon_q[i].a1, mon_q[i].d0, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
      end
    end
    for (int b = 0; b < 32; b++) w0c[8*b +: 8] = 8'(b);
    n_tests++;
    if (mon_q.size() > 0 && mon_q[0].d0 !== w0c) begin
      n_fail++;
      $display("FAIL full_word0_const: data %h, expected %h", mon_q[0].d0, w0c);
    end
    n_tests++;
    if (mon_q.size() > 24 && (mon_q[24].d0[255:128] !== 128'd0 || mon_q[1].cyc - mon_q[0].cyc != 32)) begin
      n_fail++;
      $display("FAIL full_tail: upper %h spacing %0d, expected 0 and 32",
               mon_q[24].d0[255:128], mon_q[1].cyc - mon_q[0].cyc);
    end
    n_tests++;
    if (d0_q.size() != 1 || d1_q.size() != 1 || d0_q[0] != lastc + 2 || d1_q[0] != lastc + 2) begin
      n_fail++;
      $display("FAIL full_done: %0d/%0d rises first at %0d, expected 1 rise at %0d",
               d0_q.size(), d1_q.size(), (d0_q.size() > 0) ? d0_q[0] : -1, lastc + 2);
    end
    n_tests++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || bus0.dmem_addr !== 11'd24 || bus1.dmem_addr !== 11'd124 ||
        (exp_q.size() > 24 && bus0.dmem_wrdata !== exp_q[24].data)) begin
      n_fail++;
      $display("FAIL full_hold: done %b busy %b addr %0d/%0d, expected 1 0 24/124",
               done0, busy0, bus0.dmem_addr, bus1.dmem_addr);
    end
  endtask

  task automatic test_gapped();
    rearm();
    for (int i = 0; i < F; i++) begin
      drive(1'b1, i == 0, 8'(i));
      drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle(4);
    n_tests++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL gap_count: %0d writes, expected %0d", mon_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < mon_q.size()) begin
      n_tests++;
      if (mon_q[i].cyc != exp_q[i].cyc || mon_q[i].w0 !== 1'b1 || mon_q[i].w1 !== 1'b1 ||
          mon_q[i].a0 !== 11'(exp_q[i].idx) || mon_q[i].a1 !== 11'(exp_q[i].idx + B1) ||
          mon_q[i].d0 !== exp_q[i].data || mon_q[i].d1 !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL gap_word%0d: cyc %0d addr %0d/%0d data %h, expected cyc %0d addr %0d/%0d data %h",
                 i, mon_q[i].cyc, mon_q[i].a0, mon_q[i].a1, mon_q[i].d1, exp_q[i].cyc, exp_q[i].idx,
                 exp_q[i].idx + B1, exp_q[i].data);
      end
    end
    n_tests++;
    if (d0_q.size() != dexp_q.size() || d1_q.size() != dexp_q.size() ||
        (dexp_q.size() > 0 && (d0_q[0] != dexp_q[0] || d1_q[0] != dexp_q[0]))) begin
      n_fail++;
      $display("FAIL gap_done: %0d/%0d rises, expected %0d", d0_q.size(), d1_q.size(), dexp_q.size());
    end
  endtask

  task automatic test_pre_sof();
    rearm();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < F; i++) drive(1'b1, i == 0, 8'($urandom));
    idle(4);
    n_tests++;
    if (mon_q.size() != exp_q.size() || mon_q.size() != 25) begin
      n_fail++;
      $display("FAIL presof_count: %0d writes, expected 25", mon_q.size());
    end
    foreach (exp_q[i]) if (i < mon_q.size()) begin
      n_tests++;
      if (mon_q[i].cyc != exp_q[i].cyc || mon_q[i].w0 !== 1'b1 || mon_q[i].w1 !== 1'b1 ||
          mon_q[i].a0 !== 11'(exp_q[i].idx) || mon_q[i].a1 !== 11'(exp_q[i].idx + B1) ||
          mon_q[i].d0 !== exp_q[i].data || mon_q[i].d1 !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL presof_word%0d: cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                 i, mon_q[i].cyc, mon_q[i].a0, mon_q[i].d0, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
      end
    end
    n_tests++;
    if (d0_q.size() != dexp_q.size() || d1_q.size() != dexp_q.size() ||
        (dexp_q.size() > 0 && (d0_q[0] != dexp_q[0] || d1_q[0] != dexp_q[0]))) begin
      n_fail++;
      $display("FAIL presof_done: %0d/%0d rises, expected %0d", d0_q.size(), d1_q.size(), dexp_q.size());
    end
  endtask

  task automatic test_mid_sof();
    rearm();
    for (int i = 0; i < 50; i++) drive(1'b1, i == 0, 8'($urandom));
    for (int i = 0; i < F; i++) drive(1'b1, i == 0, 8'($urandom));
    idle(4);
    n_tests++;
    if (mon_q.size() != exp_q.size() || mon_q.size() != 26) begin
      n_fail++;
      $display("FAIL midsof_count: %0d writes, expected 26", mon_q.size());
    end
    foreach (exp_q[i]) if (i < mon_q.size()) begin
      n_tests++;
      if (mon_q[i].cyc != exp_q[i].cyc || mon_q[i].w0 !== 1'b1 || mon_q[i].w1 !== 1'b1 ||
          mon_q[i].a0 !== 11'(exp_q[i].idx) || mon_q[i].a1 !== 11'(exp_q[i].idx + B1) ||
          mon_q[i].d0 !== exp_q[i].data || mon_q[i].d1 !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL midsof_word%0d: cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                 i, mon_q[i].cyc, mon_q[i].a0, mon_q[i].d0, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
      end
    end
    n_tests++;
    if (d0_q.size() != 1 || d1_q.size() != 1 || dexp_q.size() != 1 ||
        d0_q[0] != dexp_q[0] || d1_q[0] != dexp_q[0]) begin
      n_fail++;
      $display("FAIL midsof_done: %0d/%0d rises first at %0d, expected 1 rise at %0d",
               d0_q.size(), d1_q.size(), (d0_q.size() > 0) ? d0_q[0] : -1, (dexp_q.size() > 0) ? dexp_q[0] : -1);
    end
  endtask

  task automatic test_abort_rearm();
    int drops[2] = '{100, 32};
    foreach (drops[k]) begin
      rearm();
      for (int i = 0; i < drops[k]; i++) drive(1'b1, i == 0, 8'($urandom));
      en = 1'b0;
      drive(1'b1, 1'b0, 8'($urandom));
      idle(3);
      n_tests++;
      if (mon_q.size() != exp_q.size() || mon_q.size() != drops[k] / PPW) begin
        n_fail++;
        $display("FAIL abort%0d_count: %0d writes, expected %0d", drops[k], mon_q.size(), drops[k] / PPW);
      end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
        n_tests++;
        if (mon_q[i].cyc != exp_q[i].cyc || mon_q[i].w0 !== 1'b1 || mon_q[i].w1 !== 1'b1 ||
            mon_q[i].a0 !== 11'(exp_q[i].idx) || mon_q[i].a1 !== 11'(exp_q[i].idx + B1) ||
            mon_q[i].d0 !== exp_q[i].data || mon_q[i].d1 !== exp_q[i].data) begin
          n_fail++;
          $display("FAIL abort%0d_word%0d: cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                   drops[k], i, mon_q[i].cyc, mon_q[i].a0, mon_q[i].d0, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
        end
      end
      n_tests++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || d0_q.size() != 0) begin
        n_fail++;
        $display("FAIL abort%0d_state: busy %b/%b done %b/%b rises %0d, expected 0 0 0",
                 drops[k], busy0, busy1, done0, done1, d0_q.size());
      end
    end
    rearm();
    for (int i = 0; i < F; i++) drive(1'b1, i == 0, 8'($urandom));
    idle(3);
    n_tests++;
    if (mon_q.size() != exp_q.size() || mon_q.size() != 25) begin
      n_fail++;
      $display("FAIL rearm_count: %0d writes, expected 25", mon_q.size());
    end
    foreach (exp_q[i]) if (i < mon_q.size()) begin
      n_tests++;
      if (mon_q[i].cyc != exp_q[i].cyc || mon_q[i].w0 !== 1'b1 || mon_q[i].w1 !== 1'b1 ||
          mon_q[i].a0 !== 11'(exp_q[i].idx) || mon_q[i].a1 !== 11'(exp_q[i].idx + B1) ||
          mon_q[i].d0 !== exp_q[i].data || mon_q[i].d1 !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL rearm_word%0d: cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                 i, mon_q[i].cyc, mon_q[i].a0, mon_q[i].d0, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
      end
    end
    n_tests++;
    if (d0_q.size() != 1 || dexp_q.size() != 1 || d0_q[0] != dexp_q[0] || done0 !== 1'b1 || done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_done: rises %0d done %b/%b, expected 1 rise and done 1", d0_q.size(), done0, done1);
    end
    en = 1'b0;
    idle(1);
    n_tests++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear: done %b/%b busy %b/%b, expected 0", done0, done1, busy0, busy1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_pre_sof();
    test_mid_sof();
    test_abort_rearm();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ccd_frame_packer.md
Name: ccd_frame_packer

Overview:
- Sits between the camera pixel stream and DMEM write port b.
- Accepts a grayscale pixel stream and packs PIX_PER_WORD pixels into one 256-bit word. Writes each completed word to DMEM at a sequential word address.
- Signals frame completion to the CPU via img_done.
- Armed by the CPU's ccd_en. Its dmem_* outputs drive DMEM port b directly.

Parameters:
- PIX_W, 8, bits per pixel.
- PIX_PER_WORD, 32, pixels per DMEM word (PIX_W*PIX_PER_WORD = 256).
- FRAME_PIX, 784, pixels per frame (28x28).
- ADDR_W, 11, DMEM word address width.
- BASE_ADDR, 0, DMEM word address of the first frame word.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  capture enable from CPU (ccd_en); level-sensitive.
- pix_valid  in  1  pixel strobe; one pixel per cycle when high.
- pix_sof  in  1  start-of-frame; qualified by pix_valid, marks the first pixel of a frame.
- pix_data  in  PIX_W  pixel value.
- dmem_wren  out  1  one-cycle write strobe to DMEM port b.
- dmem_addr  out  ADDR_W  DMEM word address.
- dmem_wrdata  out  256  packed word.
- img_done  out  1  frame fully written (to CPU ccd_done).
- busy  out  1  high in ARMED or CAPTURE.

Behaviour:
- Reset values (async, rst=1): all outputs 0, state IDLE, pixel count 0, word index 0, pack register 0.
- States:
  - IDLE: enable=1 -> ARMED.
  - ARMED: pix_valid & pix_sof -> CAPTURE; that pixel is stored as pixel 0.
  - ARMED: enable=0 -> IDLE.
  - CAPTURE: accepts every pix_valid pixel. After pixel FRAME_PIX-1 is accepted -> DONE.
  - DONE: img_done=1 held. enable=0 -> IDLE, and img_done clears the same cycle IDLE is entered.
- Packing:
  - Pixel k of a word (k = count mod PIX_PER_WORD) occupies dmem_wrdata[PIX_W*k +: PIX_W]. Pixel 0 is in the LSBs.
- Write timing:
  - The cycle after the pixel with k = PIX_PER_WORD-1 is accepted: dmem_wren=1 for exactly one cycle, dmem_addr = BASE_ADDR + word_idx, dmem_wrdata = the completed word. word_idx then increments.
- Final word:
  - If FRAME_PIX is not a multiple of PIX_PER_WORD, the final partial word is written one cycle after the last pixel.
  - Unfilled byte lanes are zero.
  - Default parameters: 25 writes, addresses 0..24. Word 24 holds 16 pixels in [127:0] and 0 in [255:128].
- img_done rises the cycle after the final write (2 cycles after the last pixel) and stays high while in DONE.
- dmem_addr and dmem_wrdata hold their last values when dmem_wren=0.
- Pixels with pix_valid=1 are ignored in IDLE, in DONE, and in ARMED without pix_sof.
- pix_sof mid-CAPTURE (simultaneous with pix_valid):
  - The frame restarts: count and word_idx reset, the pack register clears, and the current pixel becomes pixel 0.
  - Already-written words are not rewritten; they are overwritten by the restarted frame.
  - A word that completes on the cycle before the sof still issues its write.
- enable dropped mid-CAPTURE: return to IDLE next cycle. No further writes are issued, except a write already scheduled from the previous cycle, which completes. img_done stays 0.
- Address arithmetic is modulo 2^ADDR_W. BASE_ADDR + word count must fit in DMEM; this is not checked.
- Throughput: pix_valid may be high every cycle with no stall. There is no backpressure; DMEM port b always accepts.
- busy=1 in ARMED and CAPTURE; 0 otherwise.

Test Plan:
- Reset behaviour: assert rst mid-CAPTURE after 40 pixels -> all outputs 0 immediately. After release, with enable=1, no write occurs until a new sof.
- Full frame: enable=1, 784 back-to-back pixels with pix_data = index mod 256, sof on pixel 0 -> 25 writes to addresses 0..24, wren pulses 32 cycles apart. Word 0 = bytes 0x00..0x1F with 0x00 in the LSB. Word 24 has upper 128 bits = 0. img_done rises 2 cycles after pixel 783.
- Gapped stream: pix_valid toggling 1-0 with BASE_ADDR=100 -> identical data to the full-frame test at addresses 100..124; no write occurs on an invalid cycle.
- Pre-sof pixels: 10 pixels with pix_sof=0 while ARMED -> ignored; the first word written contains only post-sof pixels.
- Mid-frame sof: sof again at pixel 50 -> word 0 written once from the first pass; the capture restarts at address 0 and completes 25 further writes. img_done is set only after the restarted frame.
- Abort and re-arm: drop enable at pixel 100 -> one pending write at most, no img_done, busy=0. Re-assert enable with a new frame -> normal completion. Drop enable in DONE -> img_done=0 the same cycle IDLE is entered.
